// File: rtl/eq_search_ctrl.sv
// Sequential key-search controller: scans a sync-read table from address 0 and reports the first match.
// Optional build macro EQ_SEARCH_COUNT_ALL_EN: scan every entry and count all matches on match_count.

module comparator_eq #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_eq
);

  assign o_eq = (i_a == i_b);

endmodule

module eq_search_ctrl #(
  parameter int N     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  key,
  input  logic [AW:0]   len,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [AW-1:0] match_addr
`ifdef EQ_SEARCH_COUNT_ALL_EN
  ,output logic [AW:0]  match_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_CMP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [AW:0]   LP_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_LEN_ONE = (AW+1)'(1'b1);
  localparam logic [AW-1:0] LP_IDX_ONE = AW'(1'b1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_index;
  logic [AW-1:0] w_index_nxt;
  logic [N-1:0]  r_key;
  logic [N-1:0]  w_key_nxt;
  logic [AW:0]   r_len;
  logic [AW:0]   w_len_nxt;
  logic          r_found;
  logic          w_found_nxt;
  logic [AW-1:0] r_match_addr;
  logic [AW-1:0] w_match_addr_nxt;
  logic          r_mem_rd;
  logic          r_busy;
  logic          r_done;
  logic          w_eq;
  logic          w_last;
  logic [AW:0]   w_len_clip;
`ifdef EQ_SEARCH_COUNT_ALL_EN
  logic [AW:0]   r_match_count;
  logic [AW:0]   w_match_count_nxt;
`endif

  comparator_eq #(.N(N)) u_cmp (
    .i_a  (r_key),
    .i_b  (mem_rdata),
    .o_eq (w_eq)
  );

  // Lengths beyond the table are clipped so the scan never runs off the end.
  assign w_len_clip = (len > LP_DEPTH) ? LP_DEPTH : len;
  assign w_last     = ({1'b0, r_index} == (r_len - LP_LEN_ONE));

  // Next-state and next-value logic for the scan sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_index_nxt      = r_index;
    w_key_nxt        = r_key;
    w_len_nxt        = r_len;
    w_found_nxt      = r_found;
    w_match_addr_nxt = r_match_addr;
`ifdef EQ_SEARCH_COUNT_ALL_EN
    w_match_count_nxt = r_match_count;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_key_nxt        = key;
          w_len_nxt        = w_len_clip;
          w_found_nxt      = 1'b0;
          w_match_addr_nxt = '0;
          w_index_nxt      = '0;
`ifdef EQ_SEARCH_COUNT_ALL_EN
          w_match_count_nxt = '0;
`endif
          w_state_nxt      = (w_len_clip == '0) ? S_DONE : S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        w_state_nxt = S_CMP;
      end
      S_CMP: begin
`ifdef EQ_SEARCH_COUNT_ALL_EN
        if (w_eq) begin
          w_match_count_nxt = r_match_count + LP_LEN_ONE;
          w_found_nxt       = 1'b1;
          // Only the first hit of the scan is recorded as the match address.
          if (!r_found) begin
            w_match_addr_nxt = r_index;
          end else begin
            w_match_addr_nxt = r_match_addr;
          end
        end else begin
          w_match_count_nxt = r_match_count;
        end
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_index_nxt = r_index + LP_IDX_ONE;
          w_state_nxt = S_READ;
        end
`else
        if (w_eq) begin
          w_found_nxt      = 1'b1;
          w_match_addr_nxt = r_index;
          w_state_nxt      = S_DONE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_index_nxt = r_index + LP_IDX_ONE;
          w_state_nxt = S_READ;
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers; strobes are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_index      <= '0;
      r_key        <= '0;
      r_len        <= '0;
      r_found      <= 1'b0;
      r_match_addr <= '0;
      r_mem_rd     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_index      <= w_index_nxt;
      r_key        <= w_key_nxt;
      r_len        <= w_len_nxt;
      r_found      <= w_found_nxt;
      r_match_addr <= w_match_addr_nxt;
      r_mem_rd     <= (w_state_nxt == S_READ);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

`ifdef EQ_SEARCH_COUNT_ALL_EN
  // Match counter for the all-entries scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_match_count <= '0;
    end else begin
      r_match_count <= w_match_count_nxt;
    end
  end

  assign match_count = r_match_count;
`endif

  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_index;
  assign busy       = r_busy;
  assign done       = r_done;
  assign found      = r_found;
  assign match_addr = r_match_addr;

endmodule

// File: tb/tb_eq_search_ctrl.sv
// Scoreboard bench for eq_search_ctrl: driver pushes reference-model results, a monitor checks each done pulse.
module tb_eq_search_ctrl;
  localparam int N = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  typedef struct {
    int f;
    int a;
    int lat;
    int reads;
    int cnt;
    int s;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  key = '0;
  logic [AW:0]   len = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_rdata = '0;
  logic          busy;
  logic          done;
  logic          found;
  logic [AW-1:0] match_addr;
`ifdef EQ_SEARCH_COUNT_ALL_EN
  logic [AW:0]   match_count;
`endif

  logic [N-1:0] mem [DEPTH];
  exp_t q[$];
  exp_t last_e;
  int total = 0;
  int bad = 0;
  int edge_n = 0;

  eq_search_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .len        (len),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .match_addr (match_addr)
`ifdef EQ_SEARCH_COUNT_ALL_EN
    ,.match_count (match_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: linear search over the clipped length, latency from the 2-cycles-per-entry rule.
  function automatic exp_t model(input logic [N-1:0] k, input int l, input int s);
    exp_t e;
    int lq;
    int first;
    int cnt;
    lq = (l > DEPTH) ? DEPTH : l;
    first = -1;
    cnt = 0;
    for (int i = 0; i < lq; i++) begin
      if (mem[i] == k) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    e.f = (first >= 0) ? 1 : 0;
    e.a = (first >= 0) ? first : 0;
    e.cnt = cnt;
    e.s = s;
`ifdef EQ_SEARCH_COUNT_ALL_EN
    e.lat = (lq == 0) ? 1 : 2 * lq + 1;
    e.reads = lq;
`else
    e.lat = (lq == 0) ? 1 : ((first >= 0) ? 2 * first + 3 : 2 * lq + 1);
    e.reads = (first >= 0) ? first + 1 : lq;
`endif
    return e;
  endfunction

  // Monitor: checks read address order and pops one expectation per done pulse.
  initial begin
    exp_t me;
    int rd_cnt;
    rd_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rd_cnt = 0;
      end else begin
        if (mem_rd) begin
          chk("rd_addr", int'(mem_addr), rd_cnt);
          rd_cnt++;
        end
        if (done) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
          end else begin
            me = q.pop_front();
            chk("found", int'(found), me.f);
            chk("match_addr", int'(match_addr), me.a);
            chk("latency", edge_n - me.s, me.lat);
            chk("read_count", rd_cnt, me.reads);
`ifdef EQ_SEARCH_COUNT_ALL_EN
            chk("match_count", int'(match_count), me.cnt);
`endif
          end
          rd_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic [N-1:0] k, input int l, input bit poke);
    exp_t e;
    @(negedge clk);
    chk("hold_found", int'(found), last_e.f);
    chk("hold_match_addr", int'(match_addr), last_e.a);
    key = k;
    len = l[AW:0];
    start = 1'b1;
    e = model(k, l, edge_n);
    q.push_back(e);
    last_e = e;
    @(negedge clk);
    start = 1'b0;
    key = $urandom;
    len = 5'($urandom_range(0, 31));
    if (poke && e.lat >= 3) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within 200 cycles, expected a done pulse");
      q.delete();
    end
  endtask

  task automatic table_3i();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(3 * i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int s;
    last_e = '{f: 0, a: 0, lat: 0, reads: 0, cnt: 0, s: 0};
    table_3i();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_found", int'(found), 0);
    chk("post_rst_match_addr", int'(match_addr), 0);
    chk("post_rst_mem_rd", int'(mem_rd), 0);
    chk("post_rst_done", int'(done), 0);

    // directed scans on mem[i]=3i
    issue(32'd9, 16, 1'b0);
    wait_idle();
    issue(32'd100, 16, 1'b0);
    wait_idle();
    issue(32'd0, 0, 1'b0);
    wait_idle();
    issue(32'd0, 1, 1'b0);
    wait_idle();

    // full-width key at the last entry, with ignored starts in cycles 5 and 33
    mem[15] = 32'hFFFF_FFFF;
    mem[14] = 32'h7FFF_FFFF;
    @(negedge clk);
    chk("hold_found", int'(found), last_e.f);
    key = 32'hFFFF_FFFF;
    len = 5'd16;
    start = 1'b1;
    s = edge_n;
    e = model(32'hFFFF_FFFF, 16, s);
    q.push_back(e);
    last_e = e;
    for (int j = 1; j <= 34; j++) begin
      @(negedge clk);
      start = (j == 5 || j == 33) ? 1'b1 : 1'b0;
      key = '0;
      len = 5'd0;
    end
    chk("busy_after_ignored_start", int'(busy), 0);
    chk("done_after_ignored_start", int'(done), 0);
    chk("found_held", int'(found), 1);
    chk("match_addr_held", int'(match_addr), 15);
    wait_idle();

    // key present at 2, 5 and 11
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000 + 32'(i);
    mem[2] = 32'hCAFE;
    mem[5] = 32'hCAFE;
    mem[11] = 32'hCAFE;
    issue(32'hCAFE, 16, 1'b0);
    wait_idle();
    issue(32'hCAFE, 6, 1'b0);
    wait_idle();
    issue(32'hCAFF, 20, 1'b0);
    wait_idle();

    // reset in the middle of a scan
    issue(32'hDEAD, 16, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_mem_rd", int'(mem_rd), 0);
    chk("midrst_found", int'(found), 0);
    q.delete();
    last_e = '{f: 0, a: 0, lat: 0, reads: 0, cnt: 0, s: 0};
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_idle", int'(busy), 0);

    // randomized scans over a small value alphabet, some full-width near misses
    for (int it = 0; it < 60; it++) begin
      logic [N-1:0] k;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'($urandom_range(0, 7));
      k = 32'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        k = mem[$urandom_range(0, DEPTH - 1)] ^ (32'h1 << $urandom_range(0, 31));
      end
      issue(k, $urandom_range(0, 20), 1'($urandom_range(0, 1)));
      wait_idle();
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eq_search_ctrl.md
Name: eq_search_ctrl

Overview:
- Sequential key-search controller built around one shared `comparator_eq` instance (width `N`).
- Scans a synchronous-read word memory from address 0 up to a requested length and compares each word against a latched key.
- Reports the first matching address.
- Sits between a host (start/done handshake) and a table RAM. It is the sequencer for the equality datapath.

Parameters:
- N, 32, data/key width; passed to the `comparator_eq` instance.
- DEPTH, 16, number of memory entries; power of two, at least 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; low forces reset state immediately.
- start  in  1  request a scan; sampled only in IDLE.
- key  in  N  search key; latched when start is accepted.
- len  in  AW+1  number of entries to scan (0..DEPTH); latched with key.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  AW  memory read address.
- mem_rdata  in  N  read data, valid the cycle after mem_rd.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the scan result is valid.
- found  out  1  a match was found in the last completed scan.
- match_addr  out  AW  address of the first match; 0 if none.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; index, key_q, len_q cleared.
  - mem_rd=0, mem_addr=0, busy=0, done=0, found=0, match_addr=0.
  - Reset mid-scan aborts the scan with no done pulse.
- States: IDLE, READ, CMP, DONE.
- IDLE:
  - If start=1: latch key into key_q, latch min(len, DEPTH) into len_q, clear found and match_addr, set index=0.
  - Next state: DONE if len_q=0, else READ.
  - start=0: remain in IDLE.
- READ:
  - mem_rd=1, mem_addr=index.
  - Next state: CMP.
- CMP:
  - mem_rd=0; `comparator_eq` compares key_q with mem_rdata. Full N-bit equality, no sign interpretation.
  - eq=1: found<=1, match_addr<=index, go to DONE.
  - eq=0 and index=len_q-1: go to DONE with found=0.
  - Otherwise: index<=index+1, go to READ.
  - index never wraps: the len_q-1 check terminates the scan before index would reach DEPTH.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
- found and match_addr are registered, hold from DONE until the next accepted start, and are valid during and after the done pulse.
- start while busy (including in DONE) is ignored, not queued. key and len changes while busy have no effect.
- Latency, with the start-sampling edge as cycle 0:
  - Match at entry k: done high in cycle 2k+3.
  - No match: done high in cycle 2·len_q+1.
  - len=0: done high in cycle 1, with no mem_rd issued.
- Throughput: one entry per 2 cycles; one outstanding memory read at most.

Optional Feature:
- Macro: EQ_SEARCH_COUNT_ALL_EN.
- Defined:
  - Adds output `match_count` (AW+1 bits, reset 0, cleared on an accepted start).
  - CMP does not stop on a match. Every entry up to len_q-1 is compared; match_count increments on each eq=1.
  - found=1 if any entry matched; match_addr records the first match only and is not overwritten by later matches.
  - done is always in cycle 2·len_q+1.
- Undefined:
  - match_count port is absent.
  - The scan stops at the first match, as specified above.

Test Plan:
- Reset: hold rst low 3 cycles, then release -> busy=0, done=0, found=0, match_addr=0, mem_rd=0. Assert rst mid-scan -> busy=0 immediately, no done pulse.
- Table mem[i]=3·i, key=9, len=16 -> mem_addr sequence 0,1,2,3; done in cycle 9; found=1, match_addr=3.
- Same table, key=100, len=16 -> 16 reads; done in cycle 33; found=0, match_addr=0.
- len=0, key=0 -> done in cycle 1; found=0; mem_rd never asserted.
- Width and busy handling:
  - mem[15]=32'hFFFF_FFFF, mem[14]=32'h7FFF_FFFF, key=32'hFFFF_FFFF, len=16 -> found=1, match_addr=15, done in cycle 33.
  - A start pulse in cycles 5 and 33 with key=0 -> ignored; results unchanged.
- With EQ_SEARCH_COUNT_ALL_EN: key present at addresses 2, 5 and 11, len=16 -> done in cycle 33; found=1, match_addr=2, match_count=3. Repeat with len=6 -> done in cycle 13, match_count=2.
